inert_ptch_intf: RTL and testbench

//  Producer end of the ptch/ptch_rt/vld interface consumed by the balance controller.
//  - Initializes the IMU over SPI through an SPI monarch (wrt/cmd/done/rd_data handshake).
//  - On each IMU data-ready INT, reads pitch rate and Z accel.
//  - Integrates the pitch rate, fuses it with accel-derived pitch and pulses vld.

---
 rtl/inert_ptch_intf.sv | 157 +++++++++++++++
 tb/tb_inert_ptch_intf.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_ptch_intf.sv
// Inertial pitch interface: configures the IMU over an SPI monarch, then on
// each data-ready INT reads pitch rate and Z accel, integrates the rate,
// fuses it with the accel-derived pitch and pulses vld with fresh results.
//
// SPI monarch handshake: wrt is a one-cycle start pulse and cmd is held
// stable from that cycle until the monarch answers with a one-cycle done;
// a new wrt is only issued in the cycle that consumes the previous done, so
// at most one transaction is ever outstanding.
module inert_ptch_intf #(
  parameter bit          fast_sim       = 1'b1,
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET      = 16'h00A0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt
);

  typedef enum logic [2:0] {
    INIT_WAIT, CFG, IDLE, RD_PL, RD_PH, RD_AZL, RD_AZH, UPD
  } state_t;

  // Kept as a named register so checkers can bind to the FSM state.
  state_t             state;
  logic [15:0]        timer;
  logic [1:0]         cfg_idx;
  logic               int_ff1, int_ff2;
  logic [7:0]         rate_lo, rate_hi, az_lo, az_hi;
  logic signed [26:0] ptch_int;

  logic               timer_full;
  logic signed [15:0] rt_nxt, az_comp, ptch_acc;
  logic signed [25:0] acc_prod, acc_shift;
  logic signed [26:0] fusion, ptch_int_nxt;

  // Init wait ends on the 10-bit wrap in fast simulation, 16-bit otherwise.
  assign timer_full = fast_sim ? (timer[9:0] == 10'h3FF) : (timer == 16'hFFFF);

  // Fused pitch is the top 16 bits of the integrator.
  assign ptch = ptch_int[26:11];

  // Sample arithmetic: bias removal, accel pitch estimate, fusion step.
  always_comb begin
    rt_nxt       = $signed({rate_hi, rate_lo} - PTCH_RT_OFFSET);
    az_comp      = $signed({az_hi, az_lo} - AZ_OFFSET);
    acc_prod     = $signed({{10{az_comp[15]}}, az_comp}) * 26'sd327;
    acc_shift    = acc_prod >>> 13;
    ptch_acc     = acc_shift[15:0];
    fusion       = (ptch_acc > $signed(ptch)) ? 27'sd1024 : -27'sd1024;
    ptch_int_nxt = ptch_int - $signed({{11{rt_nxt[15]}}, rt_nxt}) + fusion;
  end

  // Two-flop synchronizer for the asynchronous data-ready level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
    end
  end

  // Main sequencer: init wait, config writes, read chain, update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_WAIT;
      timer    <= 16'h0000;
      cfg_idx  <= 2'd0;
      wrt      <= 1'b0;
      cmd      <= 16'h0000;
      vld      <= 1'b0;
      ptch_rt  <= 16'h0000;
      ptch_int <= 27'sd0;
      rate_lo  <= 8'h00;
      rate_hi  <= 8'h00;
      az_lo    <= 8'h00;
      az_hi    <= 8'h00;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        INIT_WAIT: begin
          timer <= timer + 16'd1;
          if (timer_full) begin
            wrt     <= 1'b1;
            cmd     <= 16'h0D02;
            cfg_idx <= 2'd0;
            state   <= CFG;
          end
        end
        CFG: begin
          if (done) begin
            case (cfg_idx)
              2'd0: begin wrt <= 1'b1; cmd <= 16'h1053; cfg_idx <= 2'd1; end
              2'd1: begin wrt <= 1'b1; cmd <= 16'h1150; cfg_idx <= 2'd2; end
              2'd2: begin wrt <= 1'b1; cmd <= 16'h1460; cfg_idx <= 2'd3; end
              default: state <= IDLE;
            endcase
          end
        end
        IDLE: begin
          if (int_ff2) begin
            wrt   <= 1'b1;
            cmd   <= 16'hA200;
            state <= RD_PL;
          end
        end
        RD_PL: begin
          if (done) begin
            rate_lo <= rd_data[7:0];
            wrt     <= 1'b1;
            cmd     <= 16'hA300;
            state   <= RD_PH;
          end
        end
        RD_PH: begin
          if (done) begin
            rate_hi <= rd_data[7:0];
            wrt     <= 1'b1;
            cmd     <= 16'hAC00;
            state   <= RD_AZL;
          end
        end
        RD_AZL: begin
          if (done) begin
            az_lo <= rd_data[7:0];
            wrt   <= 1'b1;
            cmd   <= 16'hAD00;
            state <= RD_AZH;
          end
        end
        RD_AZH: begin
          if (done) begin
            az_hi <= rd_data[7:0];
            state <= UPD;
          end
        end
        UPD: begin
          ptch_rt  <= rt_nxt;
          ptch_int <= ptch_int_nxt;
          vld      <= 1'b1;
          state    <= IDLE;
        end
        default: state <= INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_ptch_intf.sv
// Bench for inert_ptch_intf: SPI monarch responder, integer reference model
// of the pitch fusion, directed and randomized samples.
module tb_inert_ptch_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state.
  int                 m_int = 0;
  logic [15:0]        m_rt = 16'h0000;
  logic signed [15:0] m_ptch = 16'sh0000;

  logic [15:0] cfg_cmds [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] rd_cmds  [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  inert_ptch_intf #(.fast_sim(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // Pitch fusion from the arithmetic rules, on plain integers.
  task automatic model_update(input logic [15:0] rate, input logic [15:0] az);
    logic signed [15:0] azc;
    int acc, fus;
    m_rt   = rate - 16'h0050;
    azc    = az - 16'h00A0;
    acc    = (int'(azc) * 327) >>> 13;
    fus    = (acc > int'(m_ptch)) ? 1024 : -1024;
    m_int  = m_int - int'($signed(m_rt)) + fus;
    m_int  = (m_int <<< 5) >>> 5;
    m_ptch = 16'(m_int >>> 11);
  endtask

  task automatic model_clear();
    m_int  = 0;
    m_rt   = 16'h0000;
    m_ptch = 16'sh0000;
  endtask

  // Monarch side of one transaction: catch wrt (already high or upcoming),
  // hold for a random time while watching cmd/wrt, then answer with done.
  task automatic spi_txn(input logic [7:0] byte_in, output logic got,
                         output logic [15:0] c, output logic stable);
    int waited, d;
    got = 1'b0; stable = 1'b1; c = 16'h0000; waited = 0;
    while (!wrt && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!wrt) return;
    got = 1'b1;
    c   = cmd;
    d   = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      @(posedge clk); #1;
      if (wrt || cmd !== c) stable = 1'b0;
    end
    done    = 1'b1;
    rd_data = {8'($urandom), byte_in};
    @(posedge clk); #1;
    done    = 1'b0;
    rd_data = 16'h0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if (wrt !== 1'b0) $display("FAIL reset_wrt: got %b, expected 0", wrt); else pass_cnt++;
    chk_cnt++; if (cmd !== 16'h0000) $display("FAIL reset_cmd: got %h, expected 0000", cmd); else pass_cnt++;
    chk_cnt++; if (vld !== 1'b0) $display("FAIL reset_vld: got %b, expected 0", vld); else pass_cnt++;
    chk_cnt++; if (ptch !== 16'h0000) $display("FAIL reset_ptch: got %h, expected 0000", ptch); else pass_cnt++;
    chk_cnt++; if (ptch_rt !== 16'h0000) $display("FAIL reset_ptch_rt: got %h, expected 0000", ptch_rt); else pass_cnt++;
  endtask

  // Released from reset at a negedge; expects the full init sequence.
  task automatic test_init();
    int cnt, extra;
    logic got, stable;
    logic [15:0] c;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!wrt && cnt < 2000);
    chk_cnt++; if (cnt != 1024) $display("FAIL init_delay: got %0d cycles, expected 1024", cnt); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      spi_txn(8'($urandom), got, c, stable);
      chk_cnt++;
      if (!got || c !== cfg_cmds[i] || !stable)
        $display("FAIL init_cmd%0d: got %h (seen %b stable %b), expected %h", i, c, got, stable, cfg_cmds[i]);
      else pass_cnt++;
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (wrt) extra++;
    end
    chk_cnt++; if (extra != 0) $display("FAIL idle_no_wrt: got %0d writes, expected 0", extra); else pass_cnt++;
  endtask

  task automatic reset_and_init();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    test_init();
  endtask

  // One full read chain. glitch keeps INT high through RD_PH; keep leaves
  // INT high so a new chain should start right after vld.
  task automatic run_sample(input logic [15:0] rate, input logic [15:0] az,
                            input bit glitch, input bit keep);
    logic got, stable;
    logic [15:0] c;
    logic [7:0] bytes [4];
    bytes = '{rate[7:0], rate[15:8], az[7:0], az[15:8]};
    chk_cnt++; if (ptch_rt !== m_rt) $display("FAIL hold_ptch_rt: got %h, expected %h", ptch_rt, m_rt); else pass_cnt++;
    chk_cnt++; if (ptch !== m_ptch) $display("FAIL hold_ptch: got %h, expected %h", ptch, m_ptch); else pass_cnt++;
    INT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      spi_txn(bytes[i], got, c, stable);
      if (!keep && (i == 1 || (i == 0 && !glitch))) INT = 1'b0;
      chk_cnt++;
      if (!got || c !== rd_cmds[i] || !stable)
        $display("FAIL read_cmd%0d: got %h (seen %b stable %b), expected %h", i, c, got, stable, rd_cmds[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (vld !== 1'b0) $display("FAIL vld_early: got %b, expected 0", vld); else pass_cnt++;
    model_update(rate, az);
    @(posedge clk); #1;
    chk_cnt++; if (vld !== 1'b1) $display("FAIL vld_pulse: got %b, expected 1", vld); else pass_cnt++;
    chk_cnt++; if (ptch_rt !== m_rt) $display("FAIL ptch_rt: got %h, expected %h", ptch_rt, m_rt); else pass_cnt++;
    chk_cnt++; if (ptch !== m_ptch) $display("FAIL ptch: got %h, expected %h", ptch, m_ptch); else pass_cnt++;
    @(posedge clk); #1;
    if (keep) begin
      chk_cnt++;
      if (wrt !== 1'b1 || cmd !== 16'hA200)
        $display("FAIL retrigger: got wrt %b cmd %h, expected wrt 1 cmd a200", wrt, cmd);
      else pass_cnt++;
    end else begin
      chk_cnt++;
      if (vld !== 1'b0 || wrt !== 1'b0)
        $display("FAIL after_vld: got vld %b wrt %b, expected 0 0", vld, wrt);
      else pass_cnt++;
    end
  endtask

  task automatic test_spec_values();
    run_sample(16'h0850, 16'h00A0, 1'b0, 1'b0);
    chk_cnt++; if (ptch_rt !== 16'h0800) $display("FAIL spec_rate: got %h, expected 0800", ptch_rt); else pass_cnt++;
    reset_and_init();
    run_sample(16'h0850, 16'h80A0, 1'b0, 1'b0);
    run_sample(16'h0850, 16'h80A0, 1'b0, 1'b0);
    chk_cnt++; if (ptch !== 16'hFFFD) $display("FAIL spec_neg_fusion: got %h, expected fffd", ptch); else pass_cnt++;
    reset_and_init();
    run_sample(16'h0050, 16'h10A0, 1'b0, 1'b0);
    run_sample(16'h0050, 16'h10A0, 1'b0, 1'b0);
    chk_cnt++; if (ptch !== 16'h0001) $display("FAIL spec_pos_fusion: got %h, expected 0001", ptch); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      run_sample(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic test_int_events();
    int extra;
    run_sample(16'($urandom), 16'($urandom), 1'b1, 1'b0);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (wrt) extra++;
    end
    chk_cnt++; if (extra != 0) $display("FAIL int_in_chain: got %0d extra writes, expected 0", extra); else pass_cnt++;
    done    = 1'b1;
    rd_data = 16'($urandom);
    @(posedge clk); #1;
    done    = 1'b0;
    extra   = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (wrt || vld) extra++;
    end
    chk_cnt++; if (extra != 0) $display("FAIL spurious_done: got %0d events, expected 0", extra); else pass_cnt++;
    run_sample(16'($urandom), 16'($urandom), 1'b0, 1'b1);
    INT = 1'b0;
    run_sample(16'($urandom), 16'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_chain();
    logic got, stable;
    logic [15:0] c;
    INT = 1'b1;
    spi_txn(8'($urandom), got, c, stable);
    INT = 1'b0;
    spi_txn(8'($urandom), got, c, stable);
    chk_cnt++;
    if (!got || c !== 16'hA300 || cmd !== 16'hAC00)
      $display("FAIL mid_chain_setup: got %h/%h, expected a300/ac00", c, cmd);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({wrt, vld, cmd, ptch, ptch_rt} !== 50'd0)
      $display("FAIL mid_chain_reset: got wrt %b vld %b cmd %h ptch %h ptch_rt %h, expected all 0",
               wrt, vld, cmd, ptch, ptch_rt);
    else pass_cnt++;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    test_init();
    run_sample(16'($urandom), 16'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_init();
    test_spec_values();
    test_random();
    test_int_events();
    test_reset_mid_chain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
